move_sequencer: RTL and testbench

Turn-based controller that sequences the board-update datapath. Accepts move requests from a white requester and a black requester, for example the user input path and the engine. It services only the side whose turn it is and validates each request against the alive vectors. It issues a one-cycle enable with player, piece number and move square to the board updater, then waits for its done pulse. After each move it checks for king capture, toggles the turn and counts moves.

---
 rtl/move_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
// Turn-based move sequencer for the board-update datapath.
// Serves the side to move, validates requests against the alive vectors,
// issues a one-cycle update enable and waits for the updater's done pulse.
// Then it checks for a captured king, toggles the turn and counts the move.
// Optional build macro MOVE_SEQ_OWN_SQUARE_CHECK_EN: also refuses a move onto
// a square held by another alive piece of the mover's own side.
module move_sequencer #(
  parameter int unsigned TIMEOUT      = 16,
  parameter int unsigned MC_W         = 10,
  parameter int unsigned FIRST_PLAYER = 1
) (
  input  logic            clk,
  input  logic            RST,
  input  logic            w_req_valid,
  input  logic [3:0]      w_req_piece,
  input  logic [5:0]      w_req_square,
  output logic            w_req_ack,
  output logic            w_req_rej,
  input  logic            b_req_valid,
  input  logic [3:0]      b_req_piece,
  input  logic [5:0]      b_req_square,
  output logic            b_req_ack,
  output logic            b_req_rej,
  output logic            upd_en,
  output logic            upd_player,
  output logic [3:0]      upd_piece,
  output logic [5:0]      upd_move,
  input  logic            upd_done,
  input  logic [15:0]     alive_w,
  input  logic [15:0]     alive_b,
  input  logic [95:0]     loc_w,
  input  logic [95:0]     loc_b,
  output logic            turn,
  output logic [MC_W-1:0] move_count,
  output logic            busy,
  output logic            game_over,
  output logic            winner,
  output logic            err
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_OVER  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              turn_q, turn_d;
  logic [MC_W-1:0]   move_count_q, move_count_d;
  logic              upd_en_q, upd_en_d;
  logic              upd_player_q, upd_player_d;
  logic [3:0]        upd_piece_q, upd_piece_d;
  logic [5:0]        upd_move_q, upd_move_d;
  logic              w_ack_q, w_ack_d;
  logic              w_rej_q, w_rej_d;
  logic              b_ack_q, b_ack_d;
  logic              b_rej_q, b_rej_d;
  logic              busy_q, busy_d;
  logic              game_over_q, game_over_d;
  logic              winner_q, winner_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              req_valid;
  logic [3:0]        req_piece;
  logic [5:0]        req_square;
  logic [15:0]       own_alive;
  logic [15:0]       opp_alive;
  logic              req_legal;
  logic [CNT_W-1:0]  cnt_inc;

  // Select the request and alive vectors of the side to move.
  always_comb begin
    req_valid  = turn_q ? w_req_valid  : b_req_valid;
    req_piece  = turn_q ? w_req_piece  : b_req_piece;
    req_square = turn_q ? w_req_square : b_req_square;
    own_alive  = turn_q ? alive_w : alive_b;
    opp_alive  = turn_q ? alive_b : alive_w;
  end

`ifdef MOVE_SEQ_OWN_SQUARE_CHECK_EN
  logic [95:0] own_loc;
  assign own_loc = turn_q ? loc_w : loc_b;

  // Legal: moving piece alive and no other own alive piece on the target.
  always_comb begin
    req_legal = own_alive[req_piece];
    for (int k = 0; k < 16; k++) begin
      if ((4'(k) != req_piece) && own_alive[k] && (own_loc[6*k +: 6] == req_square)) begin
        req_legal = 1'b0;
      end
    end
  end
`else
  // Locations are not consulted in this build.
  logic unused_loc;
  assign unused_loc = ^{loc_w, loc_b};

  // Legal: moving piece is alive on its own side.
  always_comb begin
    req_legal = own_alive[req_piece];
  end
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    turn_d       = turn_q;
    move_count_d = move_count_q;
    upd_en_d     = 1'b0;
    upd_player_d = upd_player_q;
    upd_piece_d  = upd_piece_q;
    upd_move_d   = upd_move_q;
    w_ack_d      = 1'b0;
    w_rej_d      = 1'b0;
    b_ack_d      = 1'b0;
    b_rej_d      = 1'b0;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    err_d        = err_q;
    cnt_d        = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // A request just refused is not looked at again in the rej cycle.
        if (req_valid && !(w_rej_q || b_rej_q)) begin
          if (req_legal) begin
            state_d      = S_ISSUE;
            upd_en_d     = 1'b1;
            upd_player_d = turn_q;
            upd_piece_d  = req_piece;
            upd_move_d   = req_square;
            w_ack_d      = turn_q;
            b_ack_d      = ~turn_q;
          end else begin
            w_rej_d = turn_q;
            b_rej_d = ~turn_q;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Error is decided in the last allowed cycle so err shows up
        // exactly TIMEOUT cycles after the issue cycle.
        if (upd_done) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT - 1)) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (!opp_alive[0]) begin
          state_d     = S_OVER;
          game_over_d = 1'b1;
          winner_d    = turn_q;
        end else begin
          state_d = S_IDLE;
          turn_d  = ~turn_q;
          if (move_count_q != '1) begin
            move_count_d = move_count_q + MC_W'(1);
          end
        end
      end
      S_OVER:  state_d = S_OVER;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= S_IDLE;
      turn_q       <= 1'(FIRST_PLAYER);
      move_count_q <= '0;
      upd_en_q     <= 1'b0;
      upd_player_q <= 1'b0;
      upd_piece_q  <= '0;
      upd_move_q   <= '0;
      w_ack_q      <= 1'b0;
      w_rej_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      b_rej_q      <= 1'b0;
      busy_q       <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      turn_q       <= turn_d;
      move_count_q <= move_count_d;
      upd_en_q     <= upd_en_d;
      upd_player_q <= upd_player_d;
      upd_piece_q  <= upd_piece_d;
      upd_move_q   <= upd_move_d;
      w_ack_q      <= w_ack_d;
      w_rej_q      <= w_rej_d;
      b_ack_q      <= b_ack_d;
      b_rej_q      <= b_rej_d;
      busy_q       <= busy_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign w_req_ack  = w_ack_q;
  assign w_req_rej  = w_rej_q;
  assign b_req_ack  = b_ack_q;
  assign b_req_rej  = b_rej_q;
  assign upd_en     = upd_en_q;
  assign upd_player = upd_player_q;
  assign upd_piece  = upd_piece_q;
  assign upd_move   = upd_move_q;
  assign turn       = turn_q;
  assign move_count = move_count_q;
  assign busy       = busy_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign err        = err_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer; expected values are hand-derived.
module tb_move_sequencer;

  logic        clk = 1'b0;
  logic        RST;
  logic        w_req_valid, b_req_valid;
  logic [3:0]  w_req_piece, b_req_piece;
  logic [5:0]  w_req_square, b_req_square;
  logic        w_req_ack, w_req_rej, b_req_ack, b_req_rej;
  logic        upd_en, upd_player, upd_done;
  logic [3:0]  upd_piece;
  logic [5:0]  upd_move;
  logic [15:0] alive_w, alive_b;
  logic [95:0] loc_w, loc_b;
  logic        turn, busy, game_over, winner, err;
  logic [9:0]  move_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  move_sequencer dut (
    .clk(clk), .RST(RST),
    .w_req_valid(w_req_valid), .w_req_piece(w_req_piece), .w_req_square(w_req_square),
    .w_req_ack(w_req_ack), .w_req_rej(w_req_rej),
    .b_req_valid(b_req_valid), .b_req_piece(b_req_piece), .b_req_square(b_req_square),
    .b_req_ack(b_req_ack), .b_req_rej(b_req_rej),
    .upd_en(upd_en), .upd_player(upd_player), .upd_piece(upd_piece), .upd_move(upd_move),
    .upd_done(upd_done), .alive_w(alive_w), .alive_b(alive_b), .loc_w(loc_w), .loc_b(loc_b),
    .turn(turn), .move_count(move_count), .busy(busy), .game_over(game_over),
    .winner(winner), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    w_req_valid = 0; w_req_piece = 0; w_req_square = 0;
    b_req_valid = 0; b_req_piece = 0; b_req_square = 0;
    upd_done = 0; alive_w = 16'hFFFF; alive_b = 16'hFFFF; loc_w = '0; loc_b = '0;
    tick(2);
    check("rst_busy", 32'(busy), 0);
    check("rst_turn", 32'(turn), 1);
    check("rst_count", 32'(move_count), 0);
    check("rst_upd_en", 32'(upd_en), 0);
    check("rst_flags", {28'd0, err, game_over, winner, w_req_ack}, 0);
    RST = 1'b0;

    // White move, black held valid out of turn.
    w_req_valid = 1; w_req_piece = 4'd15; w_req_square = 6'h18;
    b_req_valid = 1; b_req_piece = 4'd3;  b_req_square = 6'h28;
    tick(1);
    check("w_ack", 32'(w_req_ack), 1);
    check("w_upd_en", 32'(upd_en), 1);
    check("w_upd_fields", {23'd0, upd_player, upd_piece, upd_move}, {23'd0, 1'b1, 4'd15, 6'h18});
    check("b_ignored1", {30'd0, b_req_ack, b_req_rej}, 0);
    check("w_busy", 32'(busy), 1);
    w_req_valid = 0;
    tick(1);
    check("en_one_cycle", {30'd0, upd_en, w_req_ack}, 0);
    check("w_fields_stable", {22'd0, upd_player, upd_piece, upd_move}, {22'd0, 1'b1, 4'd15, 6'h18});
    tick(1);
    upd_done = 1;
    tick(1);
    upd_done = 0;
    check("b_ignored2", {30'd0, b_req_ack, b_req_rej}, 0);
    tick(1);
    check("w_done_turn", 32'(turn), 0);
    check("w_done_count", 32'(move_count), 1);
    check("w_done_idle", 32'(busy), 0);
    tick(1);
    check("b_ack", 32'(b_req_ack), 1);
    check("b_upd_fields", {23'd0, upd_player, upd_piece, upd_move}, {23'd0, 1'b0, 4'd3, 6'h28});
    b_req_valid = 0;
    tick(1);
    upd_done = 1;
    tick(1);
    upd_done = 0;
    tick(1);
    check("b_done_turn", 32'(turn), 1);
    check("b_done_count", 32'(move_count), 2);

    // Illegal request: dead piece, held valid.
    alive_w[15] = 1'b0;
    w_req_valid = 1; w_req_piece = 4'd15; w_req_square = 6'h20;
    tick(1);
    check("rej1", 32'(w_req_rej), 1);
    check("rej1_no_en", {30'd0, upd_en, w_req_ack}, 0);
    tick(1);
    check("rej_gap", 32'(w_req_rej), 0);
    tick(1);
    check("rej2", 32'(w_req_rej), 1);
    check("rej_turn_count", {21'd0, turn, move_count}, {21'd0, 1'b1, 10'd2});
    w_req_valid = 0; alive_w = 16'hFFFF;

    // Spurious done in IDLE.
    upd_done = 1;
    tick(1);
    upd_done = 0;
    tick(1);
    check("spurious_done", {20'd0, busy, turn, move_count}, {20'd0, 1'b0, 1'b1, 10'd2});

    // Timeout: no done after issue.
    w_req_valid = 1; w_req_piece = 4'd0; w_req_square = 6'h10;
    tick(1);
    check("to_issue", 32'(upd_en), 1);
    w_req_valid = 0;
    tick(15);
    check("to_not_yet", 32'(err), 0);
    tick(1);
    check("to_err", 32'(err), 1);
    w_req_valid = 1; w_req_piece = 4'd1; w_req_square = 6'h11;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("err_no_resp", {29'd0, w_req_ack, w_req_rej, upd_en}, 0);
    end
    check("err_sticky", 32'(err), 1);
    w_req_valid = 0;
    RST = 1;
    tick(1);
    RST = 0;
    check("rst_clears_err", {20'd0, err, turn, move_count}, {20'd0, 1'b0, 1'b1, 10'd0});

    // King capture.
    w_req_valid = 1; w_req_piece = 4'd1; w_req_square = 6'h30;
    tick(1);
    check("ko_ack", 32'(w_req_ack), 1);
    w_req_valid = 0;
    tick(1);
    upd_done = 1; alive_b[0] = 1'b0;
    tick(1);
    upd_done = 0;
    tick(1);
    check("ko_over", {30'd0, game_over, winner}, {30'd0, 1'b1, 1'b1});
    check("ko_turn_count", {21'd0, turn, move_count}, {21'd0, 1'b1, 10'd0});
    b_req_valid = 1; b_req_piece = 4'd2; b_req_square = 6'h05;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("over_no_resp", {29'd0, b_req_ack, b_req_rej, upd_en}, 0);
    end
    b_req_valid = 0; alive_b = 16'hFFFF;
    RST = 1;
    tick(1);
    RST = 0;
    check("rst_clears_over", {30'd0, game_over, winner}, 0);

    // Own-square occupancy.
    loc_w[6*9 +: 6] = 6'h20;
    w_req_valid = 1; w_req_piece = 4'd8; w_req_square = 6'h20;
    tick(1);
`ifdef MOVE_SEQ_OWN_SQUARE_CHECK_EN
    check("own_sq_rej", {29'd0, w_req_rej, w_req_ack, upd_en}, {29'd0, 3'b100});
`else
    check("own_sq_ack", {29'd0, w_req_rej, w_req_ack, upd_en}, {29'd0, 3'b011});
`endif
    w_req_valid = 0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
